timebase: RTL

TIMEBASE -- requirements
Module: timebase

---
 rtl/timebase_if.sv | 11 +
 rtl/timebase.sv | 67 ++++++
 2 files changed

// File: rtl/timebase_if.sv
// Divider configuration bus for the timebase: one write strobe, channel index and divider value.
interface timebase_if #(
  parameter int DIV_W = 19
);
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_we, cfg_ch, cfg_div);
  modport slave  (input  cfg_we, cfg_ch, cfg_div);
endinterface

// File: rtl/timebase.sv
// Multi-channel programmable tick generator with per-channel dividers, enable and single-step.
// Define TIMEBASE_STEP_EN to honour step requests on disabled channels; otherwise step is ignored.
module timebase #(
  parameter int CLK_FREQ   = 16_000_000,
  parameter int NUM_CH     = 2,
  parameter int DIV_W      = 19,
  parameter int INSTR_FREQ = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  timebase_if.slave         cfg,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [DIV_W-1:0] DIV0_RST = DIV_W'(CLK_FREQ / 60);
  localparam logic [DIV_W-1:0] DIVN_RST = DIV_W'(CLK_FREQ / INSTR_FREQ);

  // Counter start value for a divider; 0 and 1 both mean "tick every cycle".
  function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] step_req;

`ifdef TIMEBASE_STEP_EN
  assign step_req = step;
`else
  logic step_unused;
  assign step_unused = ^step;
  assign step_req    = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: div/cnt are a handful of flops, not a RAM, so they take a reset value like any register.
      for (int k = 0; k < NUM_CH; k++) begin
        div_q[k] <= (k == 0) ? DIV0_RST : DIVN_RST;
        cnt_q[k] <= (k == 0) ? reload(DIV0_RST) : reload(DIVN_RST);
      end
      tick <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        // Out-of-range cfg_ch matches no channel, so such writes fall through harmlessly.
        if (cfg.cfg_we && (int'(cfg.cfg_ch) == k)) begin
          div_q[k] <= cfg.cfg_div;
          cnt_q[k] <= reload(cfg.cfg_div);
          tick[k]  <= 1'b0;
        end else if (enable[k]) begin
          if (cnt_q[k] == '0) begin
            cnt_q[k] <= reload(div_q[k]);
            tick[k]  <= 1'b1;
          end else begin
            cnt_q[k] <= cnt_q[k] - DIV_W'(1);
            tick[k]  <= 1'b0;
          end
        end else begin
          tick[k] <= step_req[k];
        end
      end
    end
  end

endmodule
